// File: rtl/dot_acc_unit_if.sv
// dot_acc_unit_if: job control, term stream and result handshake bundle for dot_acc_unit.
interface dot_acc_unit_if #(parameter int LEN_W = 8);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             relu_en;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             ovf;
    logic             busy;
    modport master (
        output start, len, relu_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, ovf, busy
    );
    modport slave (
        input  start, len, relu_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, ovf, busy
    );
endinterface

// File: rtl/dot_acc_unit.sv
// dot_acc_unit: sums a programmed number of signed 32-bit MAC partials, optional ReLU, valid/ready result.
// Define DOT_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module dot_acc_unit #(parameter int LEN_W = 8) (
    input logic           clk,
    input logic           reset,
    dot_acc_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           state_q, state_d;
    logic [31:0]      acc_q, acc_d, out_q, out_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             relu_q, relu_d, ovf_q, ovf_d;
    logic [31:0]      sum, acc_nx, res;
    logic             beat, ov, last;
    assign beat = (state_q == ACCUM) && bus.in_valid;
    assign sum  = acc_q + bus.in_data;
    assign ov   = (acc_q[31] == bus.in_data[31]) && (sum[31] != acc_q[31]);
`ifdef DOT_ACC_SAT_EN
    assign acc_nx = ov ? (acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`else
    assign acc_nx = sum;
`endif
    assign last = cnt_q == len_q - LEN_W'(1);
    assign res  = (relu_q && acc_nx[31]) ? 32'h0 : acc_nx;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        relu_d  = relu_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        if (state_q == IDLE && bus.start) begin
            len_d   = bus.len;
            relu_d  = bus.relu_en;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            out_d   = '0;
            state_d = (bus.len == '0) ? DONE : ACCUM;
        end
        if (beat) begin
            acc_d = acc_nx;
            cnt_d = cnt_q + LEN_W'(1);
            ovf_d = ovf_q | ov;
            if (last) begin
                out_d   = res;
                state_d = DONE;
            end
        end
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            relu_q  <= 1'b0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            relu_q  <= relu_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end
    assign bus.in_ready  = state_q == ACCUM;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_data  = out_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_dot_acc_unit.sv
// tb_dot_acc_unit: table-driven jobs with a result scoreboard, plus backpressure and mid-job reset sequences.
module tb_dot_acc_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [32:0] sb[$];
    typedef struct {
        logic [7:0]  len;
        logic        relu;
        logic [31:0] t[4];
        int          gap;
        logic [31:0] exp_d;
        logic        exp_o;
    } vec_t;
    vec_t tbl[7];
    vec_t v9;
    dot_acc_unit_if bus ();
    dot_acc_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic finish_job();
        logic [32:0] e;
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : 33'h0;
        chk("out_data", bus.out_data, e[31:0]);
        chk("ovf", 32'(bus.ovf), 32'(e[32]));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
    endtask
    task automatic run_job(input vec_t v);
        bus.start   = 1'b1;
        bus.len     = v.len;
        bus.relu_en = v.relu;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.len     = 8'hAA;
        bus.relu_en = ~v.relu;
        chk("ovf_cleared", 32'(bus.ovf), 32'd0);
        if (v.len == 0) begin
            chk("zero_valid", 32'(bus.out_valid), 32'd1);
            chk("zero_in_ready", 32'(bus.in_ready), 32'd0);
        end else chk("accum_in_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back({v.exp_o, v.exp_d});
        for (int i = 0; i < int'(v.len); i++) begin
            if (i == 1) repeat (v.gap) begin
                bus.in_valid = 1'b0;
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = v.t[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (v.len != 0) chk("latency_valid", 32'(bus.out_valid), 32'd1);
        finish_job();
    endtask
    initial begin
        tbl[0] = '{8'd3, 1'b0, '{32'd10, 32'hFFFF_FFFC, 32'd7, 32'd0}, 0, 32'd13, 1'b0};
        tbl[1] = '{8'd2, 1'b1, '{32'hFFFF_FFEC, 32'd5, 32'd0, 32'd0}, 3, 32'd0, 1'b0};
        tbl[2] = '{8'd2, 1'b0, '{32'hFFFF_FFEC, 32'd5, 32'd0, 32'd0}, 3, 32'hFFFF_FFF1, 1'b0};
        tbl[3] = '{8'd0, 1'b0, '{32'd0, 32'd0, 32'd0, 32'd0}, 0, 32'd0, 1'b0};
`ifdef DOT_ACC_SAT_EN
        tbl[4] = '{8'd2, 1'b0, '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, 0, 32'h7FFF_FFFF, 1'b1};
        tbl[5] = '{8'd2, 1'b1, '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0}, 0, 32'd0, 1'b1};
`else
        tbl[4] = '{8'd2, 1'b0, '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, 0, 32'h8000_0000, 1'b1};
        tbl[5] = '{8'd2, 1'b1, '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0}, 0, 32'h7FFF_FFFF, 1'b1};
`endif
        tbl[6] = '{8'd4, 1'b0, '{32'd1, 32'd2, 32'd3, 32'd4}, 1, 32'd10, 1'b0};
        v9     = '{8'd1, 1'b0, '{32'd9, 32'd0, 32'd0, 32'd0}, 0, 32'd9, 1'b0};
        reset = 1'b1;
        bus.start = 1'b0;
        bus.len = '0;
        bus.relu_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 7; k++) run_job(tbl[k]);
        // backpressure: hold result while stray start/in_valid pulses arrive
        bus.start = 1'b1;
        bus.len = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd5;
        sb.push_back({1'b0, 32'd5});
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.start = c[0];
            bus.len = 8'd3;
            bus.in_valid = ~c[0];
            bus.in_data = 32'd100;
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data", bus.out_data, 32'd5);
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        finish_job();
        @(negedge clk);
        chk("bp_no_new_job", 32'(bus.busy), 32'd0);
        // reset in the middle of an accumulation
        bus.start = 1'b1;
        bus.len = 8'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd3;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        chk("mid_rst_out_data", bus.out_data, 32'd0);
        run_job(v9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
